mem_write_checker: RTL and testbench

Synthesizable, parametrised self-checking monitor for the MIPS data-memory write port. It sits beside `top`, snoops `memwrite`/`dataadr`/`writedata`, and compares the stream of stores against a programmable in-order table of expected (address, data) pairs. It reports a sticky pass/fail verdict with a failure code, and it is usable both in simulation benches and on FPGA builds.

---
 rtl/mem_write_checker_if.sv | 50 +++++
 rtl/mem_write_checker.sv | 167 ++++++++++++++++
 tb/tb_mem_write_checker.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_checker_if.sv
//------------------------------------------------------------------------------
// Module   : mem_write_checker_if
// Purpose  : Bundles the control, table-load, snoop and status signals of
//            mem_write_checker. Control and snoop signals flow from the master
//            (bench or SoC glue) to the slave (the checker). Status flows back.
// Ports    : clear, exp_wr, exp_addr, exp_data, start  - control / table load
//            memwrite, dataadr, writedata                - snooped store port
//            busy, pass, fail, fail_code, match_cnt,
//            exp_cnt                                     - status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_write_checker_if #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 8
);
  // Must match the counter width the checker derives from the same DEPTH.
  localparam int CW = $clog2(DEPTH + 1);

  logic          clear;
  logic          exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          start;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          busy;
  logic          pass;
  logic          fail;
  logic [1:0]    fail_code;
  logic [CW-1:0] match_cnt;
  logic [CW-1:0] exp_cnt;

  modport master (
    output clear, exp_wr, exp_addr, exp_data, start,
    output memwrite, dataadr, writedata,
    input  busy, pass, fail, fail_code, match_cnt, exp_cnt
  );

  modport slave (
    input  clear, exp_wr, exp_addr, exp_data, start,
    input  memwrite, dataadr, writedata,
    output busy, pass, fail, fail_code, match_cnt, exp_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mem_write_checker.sv
//------------------------------------------------------------------------------
// Module   : mem_write_checker
// Purpose  : Snoops the MIPS data-memory write port and checks the stores
//            against an in-order table of expected (address, data) pairs.
//            Reports a sticky pass/fail verdict with a failure code.
// Ports    : clk   - clock, all state changes on the rising edge
//            reset - asynchronous active-low reset
//            bus   - mem_write_checker_if.slave (control, snoop, status)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_write_checker #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int DEPTH   = 8,
  parameter int STRICT  = 0,
  parameter int TIMEOUT = 1024
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mem_write_checker_if.slave bus
);

  localparam int CW   = $clog2(DEPTH + 1);
  // Table is rounded up to a power of two so a slice of the counter can index
  // it without width mismatch; entries at or beyond DEPTH are never written.
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NENT = 1 << IW;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [TW-1:0] C_TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_busy;
  logic          r_pass;
  logic          r_fail;
  logic [1:0]    r_fail_code;
  logic [CW-1:0] r_match_cnt;
  logic [CW-1:0] r_exp_cnt;
  logic [TW-1:0] r_tmo;

  logic [AW-1:0] r_tab_addr [NENT];
  logic [DW-1:0] r_tab_data [NENT];

  logic          w_load;
  logic [CW-1:0] w_exp_cnt_nxt;
  logic [AW-1:0] w_cur_addr;
  logic [DW-1:0] w_cur_data;
  logic          w_addr_hit;
  logic          w_data_hit;
  logic [CW-1:0] w_match_nxt;
  logic          w_last;
  logic          w_verdict;
  logic          w_tmo_hit;
  logic          w_start;

  // clear beats exp_wr, and a full table silently drops further loads.
  assign w_load        = (r_state == S_IDLE) && bus.exp_wr && !bus.clear &&
                         (r_exp_cnt != C_DEPTH);
  assign w_exp_cnt_nxt = r_exp_cnt + CW'(w_load);

  // Entry currently awaited; match_cnt < exp_cnt <= DEPTH whenever in RUN.
  assign w_cur_addr  = r_tab_addr[r_match_cnt[IW-1:0]];
  assign w_cur_data  = r_tab_data[r_match_cnt[IW-1:0]];
  assign w_addr_hit  = bus.memwrite && (bus.dataadr == w_cur_addr);
  assign w_data_hit  = (bus.writedata == w_cur_data);
  assign w_match_nxt = r_match_cnt + CW'(1);
  assign w_last      = (w_match_nxt == r_exp_cnt);

  // A verdict is any store that ends the run; it outranks the timeout.
  assign w_verdict = w_addr_hit ? (!w_data_hit || w_last)
                                : (bus.memwrite && (STRICT != 0));
  assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo == C_TMO_LAST);

  assign w_start   = bus.start && (r_state != S_RUN);

  // Table storage has no reset: contents are meaningless until loaded.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_tab_addr[r_exp_cnt[IW-1:0]] <= bus.exp_addr;
      r_tab_data[r_exp_cnt[IW-1:0]] <= bus.exp_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= 2'd0;
      r_match_cnt <= '0;
      r_exp_cnt   <= '0;
      r_tmo       <= '0;
    end else if (bus.clear) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= 2'd0;
      r_match_cnt <= '0;
      r_exp_cnt   <= '0;
      r_tmo       <= '0;
    end else begin
      if (w_load) begin
        r_exp_cnt <= w_exp_cnt_nxt;
      end

      if (w_start) begin
        r_match_cnt <= '0;
        r_fail_code <= 2'd0;
        r_tmo       <= '0;
        r_fail      <= 1'b0;
        // A load on the start edge counts, so the updated count decides.
        if (w_exp_cnt_nxt == '0) begin
          r_state <= S_PASS;
          r_pass  <= 1'b1;
          r_busy  <= 1'b0;
        end else begin
          r_state <= S_RUN;
          r_pass  <= 1'b0;
          r_busy  <= 1'b1;
        end
      end else if (r_state == S_RUN) begin
        r_tmo <= r_tmo + TW'(1);
        if (w_addr_hit && w_data_hit) begin
          r_match_cnt <= w_match_nxt;
        end
        if (w_verdict) begin
          r_busy <= 1'b0;
          if (w_addr_hit && w_data_hit) begin
            r_state <= S_PASS;
            r_pass  <= 1'b1;
          end else begin
            r_state     <= S_FAIL;
            r_fail      <= 1'b1;
            r_fail_code <= w_addr_hit ? 2'd1 : 2'd2;
          end
        end else if (w_tmo_hit) begin
          r_state     <= S_FAIL;
          r_busy      <= 1'b0;
          r_fail      <= 1'b1;
          r_fail_code <= 2'd3;
        end
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.pass      = r_pass;
  assign bus.fail      = r_fail;
  assign bus.fail_code = r_fail_code;
  assign bus.match_cnt = r_match_cnt;
  assign bus.exp_cnt   = r_exp_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_write_checker.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_write_checker
// Purpose  : Self-checking bench for mem_write_checker. Two checkers (lenient
//            and strict) see identical stimulus; a behavioural model predicts
//            both, and directed scenarios pin the model with literal values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_write_checker;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;

  logic clk;
  logic rst_n;

  logic          s_clear, s_exp_wr, s_start, s_memwrite;
  logic [AW-1:0] s_exp_addr, s_dataadr;
  logic [DW-1:0] s_exp_data, s_writedata;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 0;

  mem_write_checker_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) if0 ();
  mem_write_checker_if #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) if1 ();

  assign if0.clear = s_clear;       assign if1.clear = s_clear;
  assign if0.exp_wr = s_exp_wr;     assign if1.exp_wr = s_exp_wr;
  assign if0.exp_addr = s_exp_addr; assign if1.exp_addr = s_exp_addr;
  assign if0.exp_data = s_exp_data; assign if1.exp_data = s_exp_data;
  assign if0.start = s_start;       assign if1.start = s_start;
  assign if0.memwrite = s_memwrite; assign if1.memwrite = s_memwrite;
  assign if0.dataadr = s_dataadr;   assign if1.dataadr = s_dataadr;
  assign if0.writedata = s_writedata; assign if1.writedata = s_writedata;

  mem_write_checker #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STRICT(0), .TIMEOUT(TIMEOUT))
    u_dut0 (.clk(clk), .reset(rst_n), .bus(if0.slave));
  mem_write_checker #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STRICT(1), .TIMEOUT(TIMEOUT))
    u_dut1 (.clk(clk), .reset(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (index 0 lenient, 1 strict) ----------
  int            m_mode [2];
  int            m_mcnt [2];
  int            m_ecnt [2];
  int            m_code [2];
  int            m_rcyc [2];   // RUN edges seen in the current run
  logic [AW-1:0] m_ta [2][DEPTH];
  logic [DW-1:0] m_td [2][DEPTH];

  task automatic m_begin(input int k);
    m_mcnt[k] = 0;
    m_code[k] = 0;
    m_rcyc[k] = 0;
    m_mode[k] = (m_ecnt[k] == 0) ? M_PASS : M_RUN;
  endtask

  task automatic m_step(input int k);
    bit done;
    if (!rst_n || s_clear) begin
      m_mode[k] = M_IDLE; m_mcnt[k] = 0; m_ecnt[k] = 0; m_code[k] = 0; m_rcyc[k] = 0;
    end else if (m_mode[k] == M_IDLE) begin
      if (s_exp_wr && m_ecnt[k] < DEPTH) begin
        m_ta[k][m_ecnt[k]] = s_exp_addr;
        m_td[k][m_ecnt[k]] = s_exp_data;
        m_ecnt[k]++;
      end
      if (s_start) m_begin(k);
    end else if (m_mode[k] != M_RUN) begin
      if (s_start) m_begin(k);
    end else begin
      m_rcyc[k]++;
      done = 0;
      if (s_memwrite) begin
        if (s_dataadr == m_ta[k][m_mcnt[k]]) begin
          if (s_writedata == m_td[k][m_mcnt[k]]) begin
            m_mcnt[k]++;
            if (m_mcnt[k] == m_ecnt[k]) begin m_mode[k] = M_PASS; done = 1; end
          end else begin
            m_mode[k] = M_FAIL; m_code[k] = 1; done = 1;
          end
        end else if (k == 1) begin
          m_mode[k] = M_FAIL; m_code[k] = 2; done = 1;
        end
      end
      if (!done && m_rcyc[k] == TIMEOUT) begin
        m_mode[k] = M_FAIL; m_code[k] = 3;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    m_step(0);
    m_step(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cmp_one(input int k, input logic b, input logic p, input logic f,
                         input logic [1:0] c, input logic [1:0] mc, input logic [1:0] ec);
    chk($sformatf("model busy[%0d]", k),      32'(b),  32'(m_mode[k] == M_RUN));
    chk($sformatf("model pass[%0d]", k),      32'(p),  32'(m_mode[k] == M_PASS));
    chk($sformatf("model fail[%0d]", k),      32'(f),  32'(m_mode[k] == M_FAIL));
    chk($sformatf("model fail_code[%0d]", k), 32'(c),  32'(m_code[k]));
    chk($sformatf("model match_cnt[%0d]", k), 32'(mc), 32'(m_mcnt[k]));
    chk($sformatf("model exp_cnt[%0d]", k),   32'(ec), 32'(m_ecnt[k]));
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      cmp_one(0, if0.busy, if0.pass, if0.fail, if0.fail_code, if0.match_cnt, if0.exp_cnt);
      cmp_one(1, if1.busy, if1.pass, if1.fail, if1.fail_code, if1.match_cnt, if1.exp_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int a, input int d);
    s_exp_wr = 1; s_exp_addr = AW'(a); s_exp_data = DW'(d);
    tick();
    s_exp_wr = 0;
  endtask

  task automatic store(input int a, input int d);
    s_memwrite = 1; s_dataadr = AW'(a); s_writedata = DW'(d);
    tick();
    s_memwrite = 0;
  endtask

  task automatic pulse_start();
    s_start = 1; tick(); s_start = 0;
  endtask

  task automatic pulse_clear();
    s_clear = 1; tick(); s_clear = 0;
  endtask

  initial begin
    int n;
    s_clear = 0; s_exp_wr = 0; s_start = 0; s_memwrite = 0;
    s_exp_addr = '0; s_exp_data = '0; s_dataadr = '0; s_writedata = '0;
    rst_n = 1;
    #1 rst_n = 0;
    tick(); tick();
    rst_n = 1;
    cmp_en = 1;
    tick();

    // Reset state
    chk("reset busy", 32'(if0.busy), 0);
    chk("reset pass", 32'(if0.pass), 0);
    chk("reset fail", 32'(if0.fail), 0);
    chk("reset fail_code", 32'(if0.fail_code), 0);
    chk("reset match_cnt", 32'(if0.match_cnt), 0);
    chk("reset exp_cnt", 32'(if0.exp_cnt), 0);

    // Overfill: third entry is dropped
    load(80, 7); load(20, 28); load(99, 1);
    chk("overfill exp_cnt", 32'(if0.exp_cnt), 2);

    // Basic pass (lenient) / unexpected address (strict)
    pulse_start();
    chk("start busy", 32'(if0.busy), 1);
    store(84, 5);
    chk("scratch ignored match_cnt", 32'(if0.match_cnt), 0);
    chk("scratch ignored busy", 32'(if0.busy), 1);
    chk("strict fail", 32'(if1.fail), 1);
    chk("strict fail_code", 32'(if1.fail_code), 2);
    chk("strict match_cnt", 32'(if1.match_cnt), 0);
    store(80, 7);
    chk("first match match_cnt", 32'(if0.match_cnt), 1);
    store(20, 28);
    chk("basic pass", 32'(if0.pass), 1);
    chk("basic fail", 32'(if0.fail), 0);
    chk("basic match_cnt", 32'(if0.match_cnt), 2);
    chk("basic busy", 32'(if0.busy), 0);

    // Data mismatch, then sticky fail
    pulse_start();
    store(80, 6);
    chk("mismatch fail", 32'(if0.fail), 1);
    chk("mismatch fail_code", 32'(if0.fail_code), 1);
    chk("mismatch match_cnt", 32'(if0.match_cnt), 0);
    store(80, 7);
    chk("sticky fail", 32'(if0.fail), 1);

    // Rerun without reload
    pulse_start();
    store(80, 7); store(20, 28);
    chk("rerun pass", 32'(if0.pass), 1);

    // Timeout: fail visible exactly TIMEOUT cycles after RUN entry
    pulse_start();
    n = 0;
    while (!if0.fail && n < 40) begin tick(); n++; end
    chk("timeout cycles", 32'(n), 16);
    chk("timeout fail_code", 32'(if0.fail_code), 3);

    // Clear then empty-table start
    pulse_clear();
    chk("clear exp_cnt", 32'(if0.exp_cnt), 0);
    chk("clear fail", 32'(if0.fail), 0);
    pulse_start();
    chk("empty start pass", 32'(if0.pass), 1);
    chk("empty start busy", 32'(if0.busy), 0);

    // Asynchronous reset mid-RUN
    pulse_clear();
    load(80, 7); load(20, 28);
    pulse_start();
    store(80, 7);
    chk("pre-reset match_cnt", 32'(if0.match_cnt), 1);
    #2 rst_n = 0;
    #1;
    chk("async reset busy", 32'(if0.busy), 0);
    chk("async reset match_cnt", 32'(if0.match_cnt), 0);
    chk("async reset pass", 32'(if0.pass), 0);
    chk("async reset fail", 32'(if0.fail), 0);
    tick();
    rst_n = 1;
    tick();
    chk("post-reset busy", 32'(if0.busy), 0);
    chk("post-reset exp_cnt", 32'(if0.exp_cnt), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      s_clear  = ($urandom_range(0, 99) < 2);
      s_start  = ($urandom_range(0, 99) < 6);
      s_exp_wr = ($urandom_range(0, 99) < 25);
      s_exp_addr = AW'($urandom_range(0, 3) * 4);
      s_exp_data = DW'($urandom_range(0, 3));
      s_memwrite = ($urandom_range(0, 99) < 60);
      if (m_mode[0] == M_RUN && m_mcnt[0] < m_ecnt[0] && $urandom_range(0, 1) == 1) begin
        s_dataadr   = m_ta[0][m_mcnt[0]];
        s_writedata = ($urandom_range(0, 7) == 0) ? m_td[0][m_mcnt[0]] + 1
                                                  : m_td[0][m_mcnt[0]];
      end else begin
        s_dataadr   = AW'($urandom_range(0, 4) * 4);
        s_writedata = DW'($urandom_range(0, 3));
      end
      tick();
    end
    s_clear = 0; s_start = 0; s_exp_wr = 0; s_memwrite = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
